// File: rtl/filter_collect.sv
// filter_collect: collects words from an upstream filter stage into a circular
// buffer of DEPTH entries. Each entry holds {parity, data}. When the buffer is
// full and nothing leaves in the same cycle, the new word is dropped. Each drop
// increments a saturating drop counter and sets a sticky overflow flag.
module filter_collect #(
  parameter int DEPTH = 4,
  parameter int DROPW = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [15:0]              io_x_data,
  input  logic                     io_x_valid,
  input  logic                     io_x_parity,
  output logic [15:0]              io_y_data,
  output logic                     io_y_parity,
  output logic                     io_y_valid,
  input  logic                     io_y_ready,
  output logic [$clog2(DEPTH):0]   io_count,
  output logic                     io_overflow,
  output logic [DROPW-1:0]         io_drops
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // Storage has no reset. Its contents only become visible through the head
  // mux, and that mux is masked while the buffer is empty.
  logic [16:0]      r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic [DROPW-1:0] r_drops;

  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [16:0]      w_head;

  assign w_full     = (r_count == FULL_COUNT);
  assign io_y_valid = (r_count != '0);
  // Consumer ready is meaningless while empty, so it is qualified by valid.
  assign w_pop      = io_y_valid & io_y_ready;
  // When full, a same-cycle pop frees the slot the new word lands in.
  assign w_push     = io_x_valid & (~w_full | w_pop);
  assign w_drop     = io_x_valid & w_full & ~w_pop;
  assign w_head     = r_mem[r_rptr];

  assign io_y_data   = io_y_valid ? w_head[15:0] : 16'h0000;
  assign io_y_parity = io_y_valid ? w_head[16]   : 1'b0;
  assign io_count    = r_count;
  assign io_overflow = r_overflow;
  assign io_drops    = r_drops;

  // Write an accepted word at the write pointer. A push in a reset cycle is lost.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem[r_wptr] <= {io_x_parity, io_x_data};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two. Occupancy is
  // unchanged on simultaneous push and pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Drop accounting: the counter saturates at all-ones, and the overflow flag
  // stays set until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drops    <= '0;
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drops != '1) r_drops <= r_drops + DROPW'(1);
    end
  end

endmodule

// File: tb/tb_filter_collect.sv
// Bench for filter_collect.
// Words the reference model accepts are queued in sb as they are driven.
// A monitor process pops sb and compares each time the DUT hands over a word.
// After every edge, the driver also compares occupancy, drop count, overflow
// flag and the presented head against the reference model.
module tb_filter_collect;

  localparam int DEPTH = 4;
  localparam int DROPW = 8;
  localparam int MAXD  = (1 << DROPW) - 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] io_x_data = '0;
  logic        io_x_valid = 1'b0;
  logic        io_x_parity = 1'b0;
  logic [15:0] io_y_data;
  logic        io_y_parity;
  logic        io_y_valid;
  logic        io_y_ready = 1'b0;
  logic [2:0]  io_count;
  logic        io_overflow;
  logic [7:0]  io_drops;

  filter_collect #(.DEPTH(DEPTH), .DROPW(DROPW)) dut (
    .clk(clk), .reset(reset),
    .io_x_data(io_x_data), .io_x_valid(io_x_valid), .io_x_parity(io_x_parity),
    .io_y_data(io_y_data), .io_y_parity(io_y_parity), .io_y_valid(io_y_valid),
    .io_y_ready(io_y_ready), .io_count(io_count),
    .io_overflow(io_overflow), .io_drops(io_drops)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: sb holds the expected buffer contents, oldest first.
  logic [16:0] sb[$];
  int          m_count = 0;
  int          m_drops = 0;
  bit          m_ovf   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: a handover happens at the next edge when valid && ready and
  // reset is low. Sample late in the low phase, after the inputs settle.
  always @(negedge clk) begin
    #3;
    if (!reset && io_y_valid && io_y_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", {15'd0, io_y_parity, io_y_data}, 32'hFFFF_FFFF);
      end else begin
        logic [16:0] exp_w;
        exp_w = sb.pop_front();
        check("output_word", {15'd0, io_y_parity, io_y_data}, {15'd0, exp_w});
        $display("xfer data=0x%04h parity=%0d", io_y_data, io_y_parity);
      end
    end
  end

  // One clock cycle: drive the inputs, apply the queue rules to the model,
  // then compare the DUT state after the edge.
  task automatic cycle(input bit rst, input bit v, input logic [15:0] d,
                       input bit p, input bit rdy);
    int  nxt_count, nxt_drops;
    bit  nxt_ovf, pop;
    @(negedge clk);
    reset = rst; io_x_valid = v; io_x_data = d; io_x_parity = p; io_y_ready = rdy;
    if (rst) begin
      sb.delete();
      nxt_count = 0; nxt_drops = 0; nxt_ovf = 1'b0;
    end else begin
      nxt_count = m_count; nxt_drops = m_drops; nxt_ovf = m_ovf;
      pop = (m_count > 0) && rdy;
      if (pop) nxt_count--;
      if (v) begin
        if (m_count < DEPTH || pop) begin
          sb.push_back({p, d});
          nxt_count++;
        end else begin
          nxt_ovf = 1'b1;
          if (nxt_drops < MAXD) nxt_drops++;
        end
      end
    end
    @(posedge clk);
    #1;
    m_count = nxt_count; m_drops = nxt_drops; m_ovf = nxt_ovf;
    check("count", 32'(io_count), 32'(m_count));
    check("drops", 32'(io_drops), 32'(m_drops));
    check("overflow", 32'(io_overflow), 32'(m_ovf));
    check("valid", 32'(io_y_valid), 32'(m_count != 0));
    if (m_count != 0 && sb.size() != 0)
      check("head", {15'd0, io_y_parity, io_y_data}, {15'd0, sb[0]});
    else
      check("idle_zero", {15'd0, io_y_parity, io_y_data}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state.
    cycle(1, 0, 16'h0, 0, 0);
    cycle(1, 1, 16'hDEAD, 1, 1);
    cycle(0, 0, 16'h0, 0, 0);

    // Single word with ready held high.
    cycle(0, 1, 16'h1234, 1, 1);
    cycle(0, 0, 16'h0, 0, 1);
    cycle(0, 0, 16'h0, 0, 1);

    // Fill and overflow, then drain.
    for (int i = 1; i <= 6; i++) cycle(0, 1, 16'hA000 + 16'(i), 1'(i), 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 16'h0, 0, 1);

    // Full with a simultaneous push and pop, then drain.
    cycle(1, 0, 16'h0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 16'h00B0 + 16'(i), 0, 0);
    cycle(0, 1, 16'h00B4, 1, 1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 16'h0, 0, 1);

    // Drop counter saturation.
    for (int i = 0; i < 4; i++) cycle(0, 1, 16'h0C00 + 16'(i), 0, 0);
    for (int i = 0; i < 300; i++) cycle(0, 1, 16'(i), 1'(i), 0);

    // Reset in the middle of operation, with a push in the same cycle.
    cycle(1, 0, 16'h0, 0, 0);
    for (int i = 0; i < 9; i++) cycle(0, 1, 16'h0D00 + 16'(i), 0, 0);
    cycle(0, 0, 16'h0, 0, 1);
    cycle(1, 1, 16'hBEEF, 1, 0);
    cycle(0, 1, 16'h0E01, 1, 0);
    cycle(0, 0, 16'h0, 0, 1);

    // Pointer wrap at occupancy 1.
    cycle(0, 1, 16'h0F00, 0, 0);
    for (int i = 1; i <= 10; i++) cycle(0, 1, 16'h0F00 + 16'(i), 1'(i), 1);
    cycle(0, 0, 16'h0, 0, 1);

    // Random traffic, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 60),
            16'($urandom), 1'($urandom), ($urandom_range(0, 99) < 45));
    end
    for (int i = 0; i < 6; i++) cycle(0, 0, 16'h0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/filter_collect.md
FILTER_COLLECT -- requirements
Module: filter_collect

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of buffer entries; legal values are powers of two, 2 to 16.
REQ-002 SHALL have parameter DROPW, default 8, giving the width of the drop counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port io_x_data, input, 16 bits: data word from the upstream filter stage.
REQ-006 SHALL have port io_x_valid, input, 1 bit: io_x_data/io_x_parity qualifier; upstream has no backpressure.
REQ-007 SHALL have port io_x_parity, input, 1 bit: the bit shifted out by the upstream stage, carried alongside the data word.
REQ-008 SHALL have port io_y_data, output, 16 bits: head-of-buffer data.
REQ-009 SHALL have port io_y_parity, output, 1 bit: head-of-buffer parity bit.
REQ-010 SHALL have port io_y_valid, output, 1 bit: buffer non-empty.
REQ-011 SHALL have port io_y_ready, input, 1 bit: the consumer accepts the head entry when io_y_valid && io_y_ready.
REQ-012 SHALL have port io_count, output, clog2(DEPTH)+1 bits: current occupancy.
REQ-013 SHALL have port io_overflow, output, 1 bit: sticky flag meaning a word was dropped.
REQ-014 SHALL have port io_drops, output, DROPW bits: saturating count of dropped words.

Function
REQ-015 SHALL store each entry as 17 bits {parity, data} in a circular buffer of DEPTH entries, with write and read pointers wrapping modulo DEPTH.
REQ-016 SHALL define push as io_x_valid=1 and pop as io_y_valid && io_y_ready.
REQ-017 SHALL accept a push when io_count < DEPTH, or when io_count == DEPTH and a pop occurs in the same cycle.
REQ-018 SHALL discard a push arriving when io_count == DEPTH with no same-cycle pop; the buffer contents and pointers SHALL remain unchanged.
REQ-019 SHALL, on each discarded push, increment io_drops, saturating at 2^DROPW-1 with no wrap, and set io_overflow, which then stays 1 until reset.
REQ-020 SHALL NOT bypass the buffer: a word pushed at rising edge N appears on io_y_* with io_y_valid=1 from edge N onward, visible in cycle N+1; minimum latency is 1 cycle.
REQ-021 SHALL present the head entry combinationally from storage; io_y_data and io_y_parity SHALL be 0 whenever io_y_valid=0.
REQ-022 SHALL update io_count by +1 on push-only, -1 on pop-only, and 0 on simultaneous push and pop or on idle; io_count SHALL never exceed DEPTH or go below 0.
REQ-023 SHALL, on simultaneous push and pop with io_count == 1, pop the old head and leave the new word as the sole entry on the next cycle.
REQ-024 SHALL ignore io_y_ready when io_y_valid=0.
REQ-025 SHALL preserve arrival order exactly; io_x_parity SHALL travel with its own data word.
REQ-026 SHALL hold io_y_data and io_y_parity stable while io_y_valid=1 and io_y_ready=0.
REQ-027 SHALL drive io_count from the registered occupancy counter; io_y_valid SHALL be (io_count != 0).

Reset
REQ-028 SHALL, when reset=1 at a rising edge, clear both pointers, io_count, io_drops and io_overflow to 0; io_y_valid SHALL be 0 and io_y_data/io_y_parity SHALL be 0 in the following cycle.
REQ-029 SHALL let reset take priority over any same-cycle push or pop; that push is lost and is not counted as a drop.
REQ-030 SHALL leave storage contents unspecified after reset; they are unobservable because outputs are masked while empty.

Verification (DEPTH=4, DROPW=8)
REQ-031 SHALL cover single word: push 0x1234 with parity 1 at edge 1, ready=1 -> in cycle 2, io_y_valid=1, io_y_data=0x1234, io_y_parity=1, io_count=1; in cycle 3, io_y_valid=0, io_y_data=0.
REQ-032 SHALL cover fill and overflow: ready=0, push 0xA001..0xA006 on consecutive cycles -> io_count=4, io_drops=2, io_overflow=1, head=0xA001; then drain with ready=1 -> output order 0xA001, 0xA002, 0xA003, 0xA004.
REQ-033 SHALL cover full with simultaneous push and pop: buffer full (0xB0..0xB3), push 0xB4 with ready=1 -> io_count stays 4, io_drops unchanged, drain order 0xB1, 0xB2, 0xB3, 0xB4.
REQ-034 SHALL cover drop saturation: buffer full, ready=0, 300 pushes -> io_drops=255, io_overflow=1.
REQ-035 SHALL cover reset mid-operation: io_count=3, io_drops=5, reset asserted with push=1 -> next cycle io_count=0, io_drops=0, io_overflow=0, io_y_valid=0; a push after reset appears 1 cycle later.
REQ-036 SHALL cover pointer wrap: 10 push/pop pairs at occupancy 1 with ready=1 -> every word emitted in order, io_count stays 1, no drops.
